// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, ALUOp encodings and the decoded
// control bundle carried from ID into EX.
package mips_pkg;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10,
      ALU_ADDI  = 2'b11
   } alu_op_t;

   typedef struct packed {
      logic    reg_dst;
      logic    alu_src;
      logic    branch;
      logic    mem_read;
      logic    mem_write;
      logic    reg_write;
      logic    mem_to_reg;
      alu_op_t alu_op;
   } ctrl_t;

   // Unknown opcodes decode to an all-zero bundle, i.e. a NOP.
   function automatic ctrl_t decode_ctrl(input logic [5:0] op);
      ctrl_t c;
      c = '0;
      unique case (op)
         OP_RTYPE: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_FUNCT; end
         OP_LW:    begin c.alu_src = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1;
                         c.reg_write = 1'b1; c.alu_op = ALU_ADD; end
         OP_SW:    begin c.alu_src = 1'b1; c.mem_write = 1'b1; c.alu_op = ALU_ADD; end
         OP_BEQ:   begin c.branch = 1'b1; c.alu_op = ALU_SUB; end
         OP_ADDI:  begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_ADDI; end
         default:  c = '0;
      endcase
      return c;
   endfunction

   function automatic logic is_known_op(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_ADDI);
   endfunction

   function automatic logic uses_rt(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
   endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports with write-through,
// one synchronous write port, r0 hardwired to zero.
module reg_file
   import mips_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [4:0]        waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [4:0]        raddr1,
   input  logic [4:0]        raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2
);

   logic [DATA_W-1:0] mem [NUM_REGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      end else if (we && (waddr != 5'd0)) begin
         mem[waddr] <= wdata;
      end
   end

   // A same-cycle writeback to the address being read wins over the array.
   always_comb begin
      rdata1 = mem[raddr1];
      rdata2 = mem[raddr2];
      if (we && (waddr == raddr1)) rdata1 = wdata;
      if (we && (waddr == raddr2)) rdata2 = wdata;
      if (raddr1 == 5'd0) rdata1 = '0;
      if (raddr2 == 5'd0) rdata2 = '0;
   end

endmodule

// File: rtl/instr_decode.sv
// MIPS ID stage: register read, control decode, immediate extension,
// load-use hazard detection and the ID/EX pipeline register.
module instr_decode
   import mips_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       instr,
   input  logic [DATA_W-1:0] pc_4,
   input  logic              flush,
   input  logic              wb_reg_write,
   input  logic [4:0]        wb_write_reg,
   input  logic [DATA_W-1:0] wb_write_data,
   output logic              stall,
   output logic [DATA_W-1:0] pc_4_idex,
   output logic [DATA_W-1:0] rd1_idex,
   output logic [DATA_W-1:0] rd2_idex,
   output logic [DATA_W-1:0] imm_idex,
   output logic [4:0]        rt_idex,
   output logic [4:0]        rd_idex,
   output logic              reg_dst_idex,
   output logic              alu_src_idex,
   output logic              branch_idex,
   output logic              mem_read_idex,
   output logic              mem_write_idex,
   output logic              reg_write_idex,
   output logic              mem_to_reg_idex,
   output logic [1:0]        alu_op_idex
);

   logic [5:0]        op;
   logic [4:0]        rs, rt, rd;
   logic [DATA_W-1:0] rd1, rd2, imm;
   ctrl_t             ctrl;
   ctrl_t             ctrl_q;
   logic              hazard;

   assign op   = instr[31:26];
   assign rs   = instr[25:21];
   assign rt   = instr[20:16];
   assign rd   = instr[15:11];
   assign imm  = {{(DATA_W-16){instr[15]}}, instr[15:0]};
   assign ctrl = decode_ctrl(op);

   reg_file #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_reg_file (
      .clk    (clk),
      .rst    (rst),
      .we     (wb_reg_write),
      .waddr  (wb_write_reg),
      .wdata  (wb_write_data),
      .raddr1 (rs),
      .raddr2 (rt),
      .rdata1 (rd1),
      .rdata2 (rd2)
   );

   // stall is a hold request to fetch: while high, PC and IF/ID keep their
   // value and the instruction here is re-presented next cycle. It lasts one
   // cycle because the bubble it inserts clears mem_read_idex.
   always_comb begin
      hazard = 1'b0;
      if (mem_read_idex && (rt_idex != 5'd0) && is_known_op(op)) begin
         hazard = (rt_idex == rs) || (uses_rt(op) && (rt_idex == rt));
      end
      stall = hazard && !flush && !rst;
   end

   always_ff @(posedge clk) begin
      if (rst || flush || stall) begin
         pc_4_idex <= '0;
         rd1_idex  <= '0;
         rd2_idex  <= '0;
         imm_idex  <= '0;
         rt_idex   <= '0;
         rd_idex   <= '0;
         ctrl_q    <= '0;
      end else begin
         pc_4_idex <= pc_4;
         rd1_idex  <= rd1;
         rd2_idex  <= rd2;
         imm_idex  <= imm;
         rt_idex   <= rt;
         rd_idex   <= rd;
         ctrl_q    <= ctrl;
      end
   end

   assign reg_dst_idex    = ctrl_q.reg_dst;
   assign alu_src_idex    = ctrl_q.alu_src;
   assign branch_idex     = ctrl_q.branch;
   assign mem_read_idex   = ctrl_q.mem_read;
   assign mem_write_idex  = ctrl_q.mem_write;
   assign reg_write_idex  = ctrl_q.reg_write;
   assign mem_to_reg_idex = ctrl_q.mem_to_reg;
   assign alu_op_idex     = ctrl_q.alu_op;

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode: a register-file model predicts each ID/EX
// word, which is queued on drive and compared after the clock edge.
module tb_instr_decode;

   localparam int W = 147;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr, pc_4, wb_write_data;
   logic        flush, wb_reg_write;
   logic [4:0]  wb_write_reg;
   logic        stall;
   logic [31:0] pc_4_idex, rd1_idex, rd2_idex, imm_idex;
   logic [4:0]  rt_idex, rd_idex;
   logic        reg_dst_idex, alu_src_idex, branch_idex, mem_read_idex;
   logic        mem_write_idex, reg_write_idex, mem_to_reg_idex;
   logic [1:0]  alu_op_idex;

   logic [W-1:0] exp_q[$];
   logic [31:0]  model_rf [32];
   int           n_tests = 0;
   int           n_fail  = 0;

   instr_decode dut (
      .clk(clk), .rst(rst), .instr(instr), .pc_4(pc_4), .flush(flush),
      .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
      .wb_write_data(wb_write_data), .stall(stall),
      .pc_4_idex(pc_4_idex), .rd1_idex(rd1_idex), .rd2_idex(rd2_idex),
      .imm_idex(imm_idex), .rt_idex(rt_idex), .rd_idex(rd_idex),
      .reg_dst_idex(reg_dst_idex), .alu_src_idex(alu_src_idex),
      .branch_idex(branch_idex), .mem_read_idex(mem_read_idex),
      .mem_write_idex(mem_write_idex), .reg_write_idex(reg_write_idex),
      .mem_to_reg_idex(mem_to_reg_idex), .alu_op_idex(alu_op_idex)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] observed();
      return {pc_4_idex, rd1_idex, rd2_idex, imm_idex, rt_idex, rd_idex,
              reg_dst_idex, alu_src_idex, branch_idex, mem_read_idex,
              mem_write_idex, reg_write_idex, mem_to_reg_idex, alu_op_idex};
   endfunction

   // {reg_dst, alu_src, branch, mem_read, mem_write, reg_write, mem_to_reg, alu_op}
   function automatic logic [8:0] exp_ctrl(input logic [5:0] op);
      case (op)
         6'h00:   return 9'b1_0_0_0_0_1_0_10;
         6'h23:   return 9'b0_1_0_1_0_1_1_00;
         6'h2B:   return 9'b0_1_0_0_1_0_0_00;
         6'h04:   return 9'b0_0_1_0_0_0_0_01;
         6'h08:   return 9'b0_1_0_0_0_1_0_11;
         default: return 9'b0;
      endcase
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (wb_reg_write && (wb_write_reg == a)) return wb_write_data;
      return model_rf[a];
   endfunction

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic [31:0] i, input logic fl,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic exp_stall);
      logic [W-1:0] e;
      instr = i; flush = fl; pc_4 = $urandom_range(32'h0, 32'h0FFF_FFFF) & 32'hFFFF_FFFC;
      wb_reg_write = we; wb_write_reg = wr; wb_write_data = wd;
      #1;
      check({tag, "_stall"}, W'(stall), W'(exp_stall));
      if (fl || exp_stall) e = '0;
      else e = {pc_4, model_read(i[25:21]), model_read(i[20:16]),
                {{16{i[15]}}, i[15:0]}, i[20:16], i[15:11], exp_ctrl(i[31:26])};
      exp_q.push_back(e);
      if (we && wr != 5'd0) model_rf[wr] = wd;
      @(posedge clk); #1;
      wb_reg_write = 1'b0; flush = 1'b0;
      if (exp_q.size() == 0) check({tag, "_queue"}, W'(0), W'(1));
      else check({tag, "_idex"}, observed(), exp_q.pop_front());
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int k = 0; k < 32; k++) model_rf[k] = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_idex", observed(), '0);
      check("reset_stall", W'(stall), '0);
      rst = 1'b0;
   endtask

   initial begin
      instr = 32'h0; pc_4 = 32'h0; flush = 1'b0;
      wb_reg_write = 1'b0; wb_write_reg = 5'd0; wb_write_data = 32'h0;
      @(negedge clk);
      do_reset();

      // add r1,r5,r0 reads r5=0 after reset while r8 is written back.
      step("read_r5",    32'h00A00820, 0, 1, 5'd8,  32'h0000_00AA, 0);
      step("add_r8",     32'h01004820, 0, 0, 5'd0,  32'h0,         0);
      step("wthru_r10",  32'h01404820, 0, 1, 5'd10, 32'h0000_00AA, 0);
      step("pre_r3",     32'hFC000000, 0, 1, 5'd3,  32'h0000_0100, 0);
      step("pre_r5",     32'hFC000000, 0, 1, 5'd5,  32'h0000_0007, 0);
      step("lw_neg",     32'h8C62FFFC, 0, 0, 5'd0,  32'h0,         0);
      step("lu_bubble",  32'h00452020, 0, 0, 5'd0,  32'h0,         1);
      step("lu_retry",   32'h00452020, 0, 0, 5'd0,  32'h0,         0);
      step("lw_r6",      32'h8C660000, 0, 0, 5'd0,  32'h0,         0);
      step("addi_rs",    32'h20C40001, 0, 0, 5'd0,  32'h0,         1);
      step("addi_retry", 32'h20C40001, 0, 0, 5'd0,  32'h0,         0);
      step("lw_r6b",     32'h8C660000, 0, 0, 5'd0,  32'h0,         0);
      step("addi_rt",    32'h20860001, 0, 0, 5'd0,  32'h0,         0);
      step("lw_r0",      32'h8C200000, 0, 1, 5'd0,  32'h0000_DEAD, 0);
      step("r0_guard",   32'h00001820, 0, 1, 5'd0,  32'h0000_BEEF, 0);
      step("lw_r2",      32'h8C620000, 0, 0, 5'd0,  32'h0,         0);
      step("flush_lu",   32'h00452020, 1, 0, 5'd0,  32'h0,         0);
      step("beq",        32'h10220010, 0, 0, 5'd0,  32'h0,         0);
      step("sw",         32'hAC650008, 0, 0, 5'd0,  32'h0,         0);
      step("nop_op",     32'h7C65A5A5, 0, 0, 5'd0,  32'h0,         0);

      // Reset while a load-use hazard is pending.
      step("lw_r2b",     32'h8C620000, 0, 0, 5'd0,  32'h0,         0);
      instr = 32'h00452020;
      rst = 1'b1;
      for (int k = 0; k < 32; k++) model_rf[k] = 32'h0;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_mid_idex", observed(), '0);
      check("rst_mid_stall", W'(stall), '0);
      step("after_rst",  32'h00452020, 0, 0, 5'd0,  32'h0,         0);

      check("queue_empty", W'(exp_q.size()), '0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_decode.md
Name: instr_decode

Overview:
- Decode stage of the 5-stage MIPS pipeline; the consumer side of the IF/ID interface.
- Takes the instruction and PC+4 from fetch, reads the 32x32 register file, and generates control and sign-extended immediate.
- Latches everything into the ID/EX state register.
- Owns load-use hazard detection: returns a stall to fetch and accepts a flush when a branch resolves in EX/MEM.

Parameters:
- NUM_REGS, 32, register file depth; register 0 is hardwired to zero.
- DATA_W, 32, datapath width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- instr  input  32  instruction from IF/ID
- pc_4  input  32  PC+4 from IF/ID
- flush  input  1  branch taken in EX/MEM (the same signal as fetch's pcSrc)
- wb_reg_write  input  1  writeback enable
- wb_write_reg  input  5  writeback destination
- wb_write_data  input  32  writeback data
- stall  output  1  hold PC and IF/ID this cycle (combinational)
- pc_4_idex  output  32  registered PC+4
- rd1_idex  output  32  registered rs value
- rd2_idex  output  32  registered rt value
- imm_idex  output  32  registered sign-extended instr[15:0]
- rt_idex  output  5  registered instr[20:16]
- rd_idex  output  5  registered instr[15:11]
- reg_dst_idex, alu_src_idex, branch_idex, mem_read_idex, mem_write_idex, reg_write_idex, mem_to_reg_idex  output  1 each  registered control
- alu_op_idex  output  2  registered ALUOp: 00 add, 01 sub, 10 funct, 11 addi-add

Behaviour:
- Reset: all ID/EX outputs are 0, i.e. a bubble. All register file entries are 0. stall is 0.
- Register file:
  - Write at posedge when wb_reg_write=1 and wb_write_reg!=0.
  - Reads are combinational with write-through: if wb_reg_write=1 and wb_write_reg matches a nonzero read address, that read returns wb_write_data in the same cycle.
  - Reads of r0 always return 0.
- Control decode from instr[31:26]:
  - 0x00 R-type: reg_dst=1, reg_write=1, alu_op=10.
  - 0x23 lw: alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, alu_op=00.
  - 0x2B sw: alu_src=1, mem_write=1, alu_op=00.
  - 0x04 beq: branch=1, alu_op=01.
  - 0x08 addi: alu_src=1, reg_write=1, alu_op=11.
  - Any other opcode: all control 0 (NOP); data fields are still latched.
- Immediate: {16{instr[15]}, instr[15:0]}.
- Source usage: rs is used by all decoded opcodes. rt is used only by R-type, sw and beq.
- Load-use hazard: stall=1 when all of the following hold:
  - mem_read_idex=1
  - rt_idex!=0
  - rt_idex equals rs, or equals rt where rt is used.
- Stall effect: while stall=1, ID/EX loads a bubble (all control 0; data fields don't-care but loaded as 0). Fetch holds, so the same instruction is re-presented the next cycle.
- Stall duration: one cycle per hazard. After the bubble, mem_read_idex=0, so stall drops automatically.
- Flush: when flush=1, ID/EX loads a bubble and stall is forced to 0. Flush has priority over stall and over a normal load.
- Otherwise: ID/EX loads the decoded values every posedge. Latency from IF/ID to ID/EX is 1 cycle.
- Reset has priority over flush, stall and writeback. Reset mid-stall clears the bubble state; stall is 0 on the following cycle.

Decomposition:
- Shared package mips_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI), ALUOp encodings, DATA_W.
- One sub-module, reg_file: 32x32, two combinational read ports with write-through, one synchronous write port, synchronous reset, r0 hardwired to zero.
- Control decode and hazard logic stay inline.

Test Plan:
- Reset: assert rst for 2 cycles -> all ID/EX outputs 0, stall=0; read r5 returns 0.
- Writeback then read: wb write r8=0x0000_00AA, next cycle instr add r9,r8,r0 (0x01004820) -> after 1 clk rd1_idex=0xAA, rd_idex=9, reg_dst=1, alu_op=10, reg_write=1. Repeat with the write in the same cycle as the read -> still 0xAA via write-through.
- Immediate and lw: lw r2,-4(r3) (0x8C62FFFC) -> imm_idex=0xFFFF_FFFC, rt_idex=2, alu_src=1, mem_read=1, mem_to_reg=1.
- Load-use: lw r2,0(r3) then add r4,r2,r5 -> stall=1 for exactly one cycle and ID/EX holds a bubble. The next cycle the add is latched with stall=0. Using addi r4,r6,1 after a lw to r6 also stalls; addi r6,r4,1 after a lw to r6 does not.
- r0 guard: lw r0,0(r1) then add r3,r0,r0 -> no stall; write to r0 is ignored, r0 still reads 0.
- Flush priority: flush=1 in the same cycle as a load-use hazard -> stall=0 and ID/EX is a bubble; beq opcode without flush -> branch_idex=1, alu_op=01.
